bcd_key_encoder: RTL

Converts nine raw key lines, one per digit 1–9, into a stream of 4-bit BCD codes, performing the inverse of the team's one-hot BCD digit decoder. Per press, the block synchronizes and debounces the keys, then priority-encodes the stable pattern. Each press produces exactly one code, pushed through a 2-entry valid/ready output FIFO. It sits between the front-panel keypad pins and the digit-entry logic.

---
 rtl/bcd_key_encoder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_key_encoder.sv
// bcd_key_encoder: nine raw key lines (digits 1..9) -> debounced, priority
// encoded BCD codes delivered through a 2-entry first-word-fall-through FIFO.
// Optional feature macro: BCD_ENC_PARITY_EN adds out_par (odd parity over
// {out_par, out_bcd}) stored alongside each FIFO entry.
module bcd_key_encoder #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] keys,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_bcd,
    output logic       out_multi,
    output logic       overflow
`ifdef BCD_ENC_PARITY_EN
    ,
    output logic       out_par
`endif
);

`ifdef BCD_ENC_PARITY_EN
    localparam int EW = 6;
`else
    localparam int EW = 5;
`endif

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    logic [8:0]    key_meta, key_s;
    state_t        state_q, state_d;
    logic [8:0]    snap_q, snap_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          emit;
    logic [3:0]    enc_bcd;
    logic          enc_multi;
    logic [EW-1:0] din;
    logic [EW-1:0] head_q, tail_q;
    logic [1:0]    count_q;
    logic          pop, push_ok;

    // Two-flop synchronizer for the asynchronous key lines
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_meta <= '0;
            key_s    <= '0;
        end else begin
            key_meta <= keys;
            key_s    <= key_meta;
        end
    end

    // Press/release FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: debounce a pattern, emit once, then wait for full release
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_s != '0) begin
                    snap_d  = key_s;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (key_s == '0) begin
                    state_d = IDLE;
                end else if (key_s != snap_q) begin
                    snap_d = key_s;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    emit    = 1'b1;
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RELEASE: begin
                // Keys still down (including newly added ones) restart the quiet timer
                if (key_s != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Priority encoder: highest pressed digit wins; flag when more than one key is down
    always_comb begin
        enc_bcd = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (snap_q[i]) enc_bcd = 4'(i + 1);
        end
        enc_multi = |(snap_q & (snap_q - 9'd1));
    end

`ifdef BCD_ENC_PARITY_EN
    assign din = {~^enc_bcd, enc_multi, enc_bcd};
`else
    assign din = {enc_multi, enc_bcd};
`endif

    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = emit && ((count_q != 2'd2) || pop);

    // Two-entry FWFT FIFO: head_q drives the outputs directly, tail_q is the second slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            head_q   <= '0;
            tail_q   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= emit && !push_ok;
            case (count_q)
                2'd0: begin
                    if (push_ok) begin
                        head_q  <= din;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push_ok && pop) begin
                        head_q <= din;
                    end else if (push_ok) begin
                        tail_q  <= din;
                        count_q <= 2'd2;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (push_ok) tail_q <= din;
                        else         count_q <= 2'd1;
                    end
                end
                default: count_q <= 2'd0;
            endcase
        end
    end

    assign out_bcd   = head_q[3:0];
    assign out_multi = head_q[4];
`ifdef BCD_ENC_PARITY_EN
    assign out_par   = head_q[5];
`endif

endmodule
